// File: rtl/sram_arbiter.sv
// Two-master round-robin arbiter for a single SRAM controller port, with a stuck-transaction timeout.
// Optional back-to-back grant locking is compiled in with `define SRAM_ARB_LOCK_EN.
module sram_arbiter #(
    parameter int TIMEOUT  = 255,
    parameter int LOCK_MAX = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_wdata,
    input  logic        m0_read,
    input  logic        m0_write,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_err,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_wdata,
    input  logic        m1_read,
    input  logic        m1_write,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_err,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_read,
    output logic        sram_write,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

    state_e          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [TW-1:0]   tmo_q, tmo_d;
`ifdef SRAM_ARB_LOCK_EN
    logic [3:0]      lock_q, lock_d;
`endif

    logic        req0, req1, sel_1, g_req, g_read, g_write, tmo_hit;
    logic        g_ready, g_err;
    logic [31:0] g_address, g_wdata, g_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            tmo_q        <= '0;
`ifdef SRAM_ARB_LOCK_EN
            lock_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            tmo_q        <= tmo_d;
`ifdef SRAM_ARB_LOCK_EN
            lock_q       <= lock_d;
`endif
        end
    end

    always_comb begin
        req0      = m0_read | m0_write;
        req1      = m1_read | m1_write;
        sel_1     = (state_q == GNT1);
        g_read    = sel_1 ? m1_read    : m0_read;
        g_write   = sel_1 ? m1_write   : m0_write;
        g_address = sel_1 ? m1_address : m0_address;
        g_wdata   = sel_1 ? m1_wdata   : m0_wdata;
        g_req     = g_read | g_write;
        tmo_hit   = (TIMEOUT != 0) && (state_q != IDLE) && !sram_ready
                    && (tmo_q == TW'(TIMEOUT));

        state_d      = state_q;
        last_grant_d = last_grant_q;
        tmo_d        = tmo_q;
`ifdef SRAM_ARB_LOCK_EN
        lock_d       = lock_q;
`endif
        sram_read    = 1'b0;
        sram_write   = 1'b0;
        sram_address = '0;
        sram_wdata   = '0;
        g_ready      = 1'b0;
        g_err        = 1'b0;
        g_rdata      = '0;

        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
`ifdef SRAM_ARB_LOCK_EN
                lock_d = '0;
`endif
                // On a tie, the master that did not win last time goes next.
                if (req0 && (!req1 || last_grant_q)) begin
                    state_d      = GNT0;
                    last_grant_d = 1'b0;
                end else if (req1) begin
                    state_d      = GNT1;
                    last_grant_d = 1'b1;
                end
            end
            GNT0, GNT1: begin
                sram_address = g_address;
                sram_wdata   = g_wdata;
                if (!tmo_hit) begin
                    sram_read  = g_read & ~g_write;
                    sram_write = g_write;
                end
                // A completion in the timeout cycle wins over the abort.
                if (sram_ready) begin
                    g_ready = 1'b1;
                    g_rdata = sram_rdata;
                    tmo_d   = '0;
                    state_d = IDLE;
`ifdef SRAM_ARB_LOCK_EN
                    if (g_req && (lock_q < 4'(LOCK_MAX - 1))) begin
                        state_d = state_q;
                        lock_d  = lock_q + 4'd1;
                    end else begin
                        lock_d  = '0;
                    end
`endif
                end else if (tmo_hit) begin
                    g_ready = 1'b1;
                    g_err   = 1'b1;
                    tmo_d   = '0;
                    state_d = IDLE;
`ifdef SRAM_ARB_LOCK_EN
                    lock_d  = '0;
`endif
                end else if (TIMEOUT != 0) begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        m0_ready = g_ready & ~sel_1;
        m0_err   = g_err   & ~sel_1;
        m0_rdata = sel_1 ? 32'd0 : g_rdata;
        m1_ready = g_ready & sel_1;
        m1_err   = g_err   & sel_1;
        m1_rdata = sel_1 ? g_rdata : 32'd0;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter (default build, TIMEOUT=8): directed steps plus a
// randomized phase scored against a transaction-level round-robin reference model.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_address, m0_wdata, m0_rdata, m1_address, m1_wdata, m1_rdata;
    logic        m0_read, m0_write, m0_ready, m0_err, m1_read, m1_write, m1_ready, m1_err;
    logic [31:0] sram_address, sram_wdata, sram_rdata;
    logic        sram_read, sram_write, sram_ready;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: who owns the SRAM port, who was served last, remaining latency.
    int          owner;
    bit          last_srv;
    int          lat_left;
    bit          rd[2], wr[2];
    logic [31:0] ad[2], wd[2];
    int          obs_q[$];

    sram_arbiter #(.TIMEOUT(8), .LOCK_MAX(2)) dut (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_wdata(m0_wdata), .m0_read(m0_read), .m0_write(m0_write),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_address(m1_address), .m1_wdata(m1_wdata), .m1_read(m1_read), .m1_write(m1_write),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
        .sram_address(sram_address), .sram_wdata(sram_wdata), .sram_read(sram_read),
        .sram_write(sram_write), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive_masters();
        m0_read = rd[0]; m0_write = wr[0]; m0_address = ad[0]; m0_wdata = wd[0];
        m1_read = rd[1]; m1_write = wr[1]; m1_address = ad[1]; m1_wdata = wd[1];
    endtask

    task automatic clear_all();
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0;
        end
        drive_masters();
        sram_ready = 1'b0;
        sram_rdata = '0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_sram_read"},  32'(sram_read),  32'd0);
        check({tag, "_sram_write"}, 32'(sram_write), 32'd0);
        check({tag, "_sram_addr"},  sram_address,    32'd0);
        check({tag, "_sram_wdata"}, sram_wdata,      32'd0);
        check({tag, "_ready"}, 32'({m1_ready, m0_ready}), 32'd0);
        check({tag, "_err"},   32'({m1_err, m0_err}),     32'd0);
        check({tag, "_m0_rdata"}, m0_rdata, 32'd0);
        check({tag, "_m1_rdata"}, m1_rdata, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_all();
        tick();
        tick();
        rst      = 1'b1;
        owner    = -1;
        last_srv = 1'b1;
        obs_q.delete();
    endtask

    task automatic new_req(input int x, input bit read_only);
        int k;
        k = read_only ? 0 : int'($urandom_range(0, 2));
        rd[x] = (k != 1);
        wr[x] = (k != 0);
        ad[x] = $urandom;
        wd[x] = $urandom;
    endtask

    // Plays both masters and the SRAM controller; compares the DUT every cycle against the model.
    task automatic run_engine(input int ncyc, input int maxlat, input bit hold);
        bit rdy, r0, r1;
        int x;
        for (int c = 0; c < ncyc; c++) begin
            rdy        = (owner >= 0) && (lat_left == 0);
            sram_ready = rdy;
            sram_rdata = $urandom;
            settle();
            if (owner < 0) begin
                check("idle_strobes", 32'({sram_write, sram_read}), 32'd0);
                check("idle_ready",   32'({m1_ready, m0_ready}),    32'd0);
            end else begin
                x = owner;
                check("gnt_write", 32'(sram_write), 32'(wr[x]));
                check("gnt_read",  32'(sram_read),  32'(rd[x] && !wr[x]));
                check("gnt_addr",  sram_address, ad[x]);
                check("gnt_wdata", sram_wdata,   wd[x]);
                check("gnt_ready", 32'({m1_ready, m0_ready}), rdy ? (x == 0 ? 32'd1 : 32'd2) : 32'd0);
                check("gnt_err",   32'({m1_err, m0_err}), 32'd0);
                if (rdy) check("gnt_rdata", (x == 1) ? m1_rdata : m0_rdata, sram_rdata);
                check("other_rdata", (x == 1) ? m0_rdata : m1_rdata, 32'd0);
                if (m0_ready) obs_q.push_back(0);
                else if (m1_ready) obs_q.push_back(1);
            end
            r0 = rd[0] | wr[0];
            r1 = rd[1] | wr[1];
            if (owner < 0) begin
                if (r0 && r1) owner = last_srv ? 0 : 1;
                else if (r0)  owner = 0;
                else if (r1)  owner = 1;
                if (owner >= 0) begin
                    last_srv = (owner == 1);
                    lat_left = $urandom_range(0, maxlat);
                end
            end else if (rdy) begin
                x     = owner;
                owner = -1;
                if (hold || $urandom_range(0, 1) == 1) new_req(x, hold);
                else begin rd[x] = 1'b0; wr[x] = 1'b0; end
            end else begin
                lat_left--;
            end
            for (int y = 0; y < 2; y++)
                if (!hold && !(rd[y] | wr[y]) && $urandom_range(0, 2) == 0) new_req(y, 1'b0);
            tick();
            drive_masters();
            sram_ready = 1'b0;
        end
    endtask

    initial begin
        int exp_ord[4];
        exp_ord = '{0, 1, 0, 1};
        rst = 1'b0;
        clear_all();
        owner = -1;
        last_srv = 1'b1;

        // Reset held with no requests: everything quiet.
        for (int i = 0; i < 10; i++) begin
            settle();
            check_quiet("reset");
            tick();
        end

        // First read from master 0: one-cycle decision, then combinational completion.
        rst = 1'b1;
        m0_read = 1'b1; m0_address = 32'h100;
        settle();
        check("rd_decide_cycle", 32'(sram_read), 32'd0);
        tick();
        settle();
        check("rd_strobe", 32'(sram_read), 32'd1);
        check("rd_addr", sram_address, 32'h100);
        check("rd_no_ready_yet", 32'(m0_ready), 32'd0);
        tick();
        sram_ready = 1'b1; sram_rdata = 32'hDEADBEEF;
        settle();
        check("rd_m0_ready", 32'(m0_ready), 32'd1);
        check("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
        check("rd_m1_ready", 32'(m1_ready), 32'd0);
        check("rd_m1_rdata", m1_rdata, 32'd0);
        tick();
        clear_all();
        settle();
        check_quiet("after_rd");

        // Master 1 with both read and write set: write wins.
        m1_read = 1'b1; m1_write = 1'b1; m1_address = 32'h40; m1_wdata = 32'h12345678;
        tick();
        settle();
        check("wr_write", 32'(sram_write), 32'd1);
        check("wr_read", 32'(sram_read), 32'd0);
        check("wr_wdata", sram_wdata, 32'h12345678);
        check("wr_addr", sram_address, 32'h40);
        tick();
        sram_ready = 1'b1;
        settle();
        check("wr_ready", 32'({m1_ready, m0_ready}), 32'd2);
        tick();
        clear_all();

        // Timeout: abort exactly 8 cycles after the strobe starts, then an IDLE cycle.
        do_reset();
        m0_read = 1'b1; m0_address = 32'h200;
        tick();
        for (int k = 0; k < 8; k++) begin
            settle();
            check("tmo_strobe", 32'(sram_read), 32'd1);
            check("tmo_no_err", 32'({m0_err, m0_ready}), 32'd0);
            tick();
        end
        settle();
        check("tmo_err", 32'({m0_err, m0_ready}), 32'd3);
        check("tmo_strobe_off", 32'({sram_write, sram_read}), 32'd0);
        tick();
        settle();
        check("tmo_then_idle", 32'(sram_read), 32'd0);
        tick();
        for (int k = 0; k < 8; k++) tick();
        sram_ready = 1'b1; sram_rdata = 32'h0BADF00D;
        settle();
        check("tmo_race_ready", 32'(m0_ready), 32'd1);
        check("tmo_race_no_err", 32'(m0_err), 32'd0);
        check("tmo_race_strobe", 32'(sram_read), 32'd1);
        check("tmo_race_rdata", m0_rdata, 32'h0BADF00D);
        tick();
        clear_all();

        // Asynchronous reset while granted to master 1.
        do_reset();
        m1_write = 1'b1; m1_address = 32'h80; m1_wdata = 32'hCAFE;
        tick();
        settle();
        check("rst_gnt1_strobe", 32'(sram_write), 32'd1);
        tick();
        sram_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rst_strobe_drop", 32'({sram_write, sram_read}), 32'd0);
        check("rst_no_ready", 32'(m1_ready), 32'd0);
        check("rst_addr_drop", sram_address, 32'd0);
        tick();
        rst = 1'b1;
        sram_ready = 1'b0;
        settle();
        check("rst_release_idle", 32'(sram_write), 32'd0);
        tick();
        settle();
        check("rst_regrant", 32'(sram_write), 32'd1);
        clear_all();

        // Both masters held: alternating service order from reset.
        do_reset();
        rd[0] = 1'b1; ad[0] = 32'h1000; rd[1] = 1'b1; ad[1] = 32'h2000;
        drive_masters();
        run_engine(12, 0, 1'b1);
        check("order_len_ok", 32'(obs_q.size() >= 4), 32'd1);
        if (obs_q.size() >= 4)
            for (int i = 0; i < 4; i++) check("order", 32'(obs_q[i]), 32'(exp_ord[i]));

        // Randomized traffic against the reference model.
        do_reset();
        run_engine(600, 4, 1'b0);
        check("random_progress", 32'(obs_q.size() > 20), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-master, one-slave arbiter sharing the single external SRAM port between the data-cache controller (master 0) and a second requester (master 1, e.g. instruction fetch or debug loader).
- Sits between the masters' sram_* outputs and the SRAM controller.
- Round-robin, one transaction per grant.
- Forwards strobes, address and write data of the granted master and routes completion back.
- Includes a stuck-transaction timeout.

Parameters:
- TIMEOUT, 255, max cycles in a grant state without sram_ready before abort; 0 disables the timeout.
- LOCK_MAX, 2, max back-to-back transactions per grant when SRAM_ARB_LOCK_EN is defined (range 1..15).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- m0_address  in  32  master 0 address.
- m0_wdata  in  32  master 0 write data.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_rdata  out  32  read data to master 0.
- m0_ready  out  1  master 0 transaction complete.
- m0_err  out  1  master 0 transaction aborted by timeout.
- m1_address, m1_wdata, m1_read, m1_write, m1_rdata, m1_ready, m1_err: same as master 0, for master 1.
- sram_address  out  32  address to SRAM controller.
- sram_wdata  out  32  write data to SRAM controller.
- sram_read  out  1  read strobe to SRAM controller.
- sram_write  out  1  write strobe to SRAM controller.
- sram_rdata  in  32  SRAM read data, valid when sram_ready=1.
- sram_ready  in  1  one-cycle completion pulse from SRAM controller.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low (rst).
- Reset: state IDLE, last_grant=1 (master 0 wins the first tie), timeout and lock counters 0.
- Reset values of all outputs: sram_read/sram_write 0, sram_address/sram_wdata 0, mX_ready 0, mX_err 0, mX_rdata 0.
- Reset asserted mid-transaction drops all strobes immediately; the master sees no ready.
- Request: reqX = mX_read | mX_write. If both are set, the write is performed and the read is ignored.
- Masters hold request, address and data stable until mX_ready or mX_err.
- States: IDLE, GNT0, GNT1.
- IDLE: no strobes.
  - Only req0 -> GNT0. Only req1 -> GNT1.
  - Both -> the master != last_grant.
  - last_grant updates at the same edge.
  - Decision takes 1 cycle: request seen in cycle N, sram strobes asserted from cycle N+1.
- GNTx: sram_address, sram_wdata, sram_read, sram_write driven combinationally from master x; the other master sees ready=0, err=0, rdata=0.
  - On sram_ready=1: mx_ready=1 and mx_rdata=sram_rdata in the same cycle (combinational passthrough); next state IDLE.
  - Non-granted master outputs are always 0.
- Timeout counter: counts cycles in GNTx with sram_ready=0.
  - When it reaches TIMEOUT: mx_err=1 and mx_ready=1 for one cycle, strobes forced 0 that cycle, next state IDLE, counter cleared.
  - sram_ready arriving in the same cycle as the timeout wins: normal completion, no err.
- A request dropped while granted (protocol violation): strobes follow the inputs (0); the state remains until sram_ready or timeout.
- Round-robin guarantees each master waits at most one other transaction plus 1 IDLE cycle (LOCK_MAX transactions when locked).

Optional Feature:
- Macro SRAM_ARB_LOCK_EN.
- Defined:
  - If the granted master's request is still asserted in its completion cycle, the grant is kept (no IDLE cycle); the next transaction's strobes start the cycle after completion.
  - A lock counter limits this to LOCK_MAX consecutive transactions, after which the state returns to IDLE.
  - Intended for cache line fills (two words, second address differing in bits [2:0]) so they run without interleaving.
- Undefined: every completion returns to IDLE for one cycle; lock counter absent.

Test Plan:
- Reset, no requests -> all outputs 0 for 10 cycles; release rst, req0 read at 0x100 -> sram_read=1, sram_address=0x100 next cycle; sram_ready with rdata 0xDEADBEEF -> m0_ready=1, m0_rdata=0xDEADBEEF same cycle.
- req0 and req1 raised in the same cycle after reset -> master 0 served first, then IDLE, then master 1; repeat with both held -> order 0,1,0,1.
- m1_write with wdata 0x12345678 at 0x40, m1_read also set -> sram_write=1, sram_read=0, sram_wdata=0x12345678.
- TIMEOUT=8, sram_ready never asserted -> m0_err=1 and m0_ready=1 exactly 8 cycles after the strobe starts, strobes 0 that cycle, state IDLE; repeat with sram_ready on cycle 8 -> no err.
- SRAM_ARB_LOCK_EN defined, LOCK_MAX=2, master 0 holds read for 3 transactions while req1 pending -> 0,0 back-to-back, then IDLE, then master 1, then the third master 0 transaction; without macro -> 0,1,0.
- rst asserted while in GNT1 with strobes active -> strobes and m1_ready drop to 0 immediately; after release, state IDLE.
